// File: rtl/fft_pkg.sv
// Shared types and address helpers for the FFT sequencing controller.
package fft_pkg;

  localparam int AW = 5;

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW-2:0] tw_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    addr_t a;
    addr_t b;
    tw_t   tw;
  } bfly_t;

  // Reverse the low w bits of v (upper bits of v are expected to be zero).
  function automatic addr_t bitrev(input addr_t v, input int w);
    addr_t full;
    full = {<<{v}};
    return full >> (AW - w);
  endfunction

  // Radix-2 DIT butterfly j of a stage: legs differ only in bit 'stage'.
  function automatic bfly_t bfly_addr(input addr_t stage, input addr_t j, input int w);
    addr_t one;
    addr_t span;
    addr_t low;
    bfly_t r;
    one  = {{(AW-1){1'b0}}, 1'b1};
    span = one << stage;
    low  = j & (span - one);
    r.a  = ((j >> stage) << (stage + one)) | low;
    r.b  = r.a | span;
    r.tw = tw_t'(low << (w - 1 - int'(stage)));
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register carrying the read strobe and both read
// addresses forward to the memory write port.
module fft_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         valid_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     a_q [DEPTH];
  logic [W-1:0]     b_q [DEPTH];

  // Shift one slot per cycle; reset flushes every slot so no write escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      a_q[0]     <= a_i;
      b_q[0]     <= b_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        a_q[i]     <= a_q[i-1];
        b_q[i]     <= b_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign a_o     = a_q[DEPTH-1];
  assign b_o     = b_q[DEPTH-1];

endmodule

// File: rtl/fft_addr_ctrl.sv
// Load/run sequencer for a ping-pong radix-2 FFT memory: bit-reversed load,
// one butterfly read per cycle, write addresses delayed to the butterfly.
module fft_addr_ctrl
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH   = AW,
  parameter int BFLY_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  init,
  output logic                  roW,
  output logic [ADDR_WIDTH-1:0] addr_A_read,
  output logic [ADDR_WIDTH-1:0] addr_B_read,
  output logic [ADDR_WIDTH-1:0] addr_A_write,
  output logic [ADDR_WIDTH-1:0] addr_B_write,
  output logic [ADDR_WIDTH-2:0] tw_addr,
  output logic                  rd_valid,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] stage,
  output logic                  busy,
  output logic                  done,
  output logic                  result_bank
);

  localparam int N    = 1 << ADDR_WIDTH;
  localparam int HALF = N / 2;
  localparam int DW   = (BFLY_LATENCY > 1) ? $clog2(BFLY_LATENCY) : 1;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] load_cnt_q;
  logic [ADDR_WIDTH-1:0] load_addr_q;
  logic [ADDR_WIDTH-1:0] stage_q;
  logic [ADDR_WIDTH-2:0] j_q;
  logic [DW-1:0]         drain_q;
  logic [ADDR_WIDTH-1:0] a_rd_q;
  logic [ADDR_WIDTH-1:0] b_rd_q;
  logic [ADDR_WIDTH-2:0] tw_q;
  logic                  init_q;
  logic                  row_q;
  logic                  load_ready_q;
  logic                  rd_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  result_bank_q;

  logic [ADDR_WIDTH-1:0] load_nxt_d;
  logic [ADDR_WIDTH-1:0] iss_stage_d;
  logic [ADDR_WIDTH-2:0] iss_j_d;
  bfly_t                 bf_d;

  logic                  dl_valid_s;
  logic [ADDR_WIDTH-1:0] dl_a_s;
  logic [ADDR_WIDTH-1:0] dl_b_s;

  // Butterfly that would be issued on the next edge, for whichever transition occurs.
  always_comb begin
    load_nxt_d  = load_cnt_q + 1'b1;
    iss_stage_d = '0;
    iss_j_d     = '0;
    case (state_q)
      ST_RUN: begin
        iss_stage_d = stage_q;
        iss_j_d     = j_q + 1'b1;
      end
      ST_DRAIN: begin
        iss_stage_d = stage_q + 1'b1;
      end
      default: begin
        iss_stage_d = '0;
      end
    endcase
    bf_d = bfly_addr(iss_stage_d, {1'b0, iss_j_d}, ADDR_WIDTH);
  end

  // Sequencer FSM; every output is a register updated with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      load_addr_q   <= '0;
      stage_q       <= '0;
      j_q           <= '0;
      drain_q       <= '0;
      a_rd_q        <= '0;
      b_rd_q        <= '0;
      tw_q          <= '0;
      init_q        <= 1'b1;
      row_q         <= 1'b0;
      load_ready_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_bank_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_LOAD;
            init_q       <= 1'b0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            load_cnt_q   <= '0;
            load_addr_q  <= '0;
            stage_q      <= '0;
            row_q        <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            if (load_cnt_q == ADDR_WIDTH'(N - 1)) begin
              state_q      <= ST_RUN;
              init_q       <= 1'b1;
              load_ready_q <= 1'b0;
              row_q        <= 1'b0;
              stage_q      <= '0;
              j_q          <= '0;
              rd_valid_q   <= 1'b1;
              a_rd_q       <= bf_d.a;
              b_rd_q       <= bf_d.b;
              tw_q         <= bf_d.tw;
            end else begin
              load_cnt_q  <= load_nxt_d;
              load_addr_q <= bitrev(load_nxt_d, ADDR_WIDTH);
            end
          end
        end
        ST_RUN: begin
          if (j_q == (ADDR_WIDTH-1)'(HALF - 1)) begin
            state_q    <= ST_DRAIN;
            rd_valid_q <= 1'b0;
            drain_q    <= '0;
          end else begin
            j_q    <= iss_j_d;
            a_rd_q <= bf_d.a;
            b_rd_q <= bf_d.b;
            tw_q   <= bf_d.tw;
          end
        end
        ST_DRAIN: begin
          // Bank swap only once the last write of the stage has left the pipe.
          if (drain_q == DW'(BFLY_LATENCY - 1)) begin
            if (stage_q == ADDR_WIDTH'(ADDR_WIDTH - 1)) begin
              state_q       <= ST_DONE;
              result_bank_q <= row_q;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
            end else begin
              state_q    <= ST_RUN;
              stage_q    <= iss_stage_d;
              row_q      <= ~row_q;
              j_q        <= '0;
              rd_valid_q <= 1'b1;
              a_rd_q     <= bf_d.a;
              b_rd_q     <= bf_d.b;
              tw_q       <= bf_d.tw;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  fft_delay_line #(
    .DEPTH (BFLY_LATENCY),
    .W     (ADDR_WIDTH)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_valid_q),
    .a_i     (a_rd_q),
    .b_i     (b_rd_q),
    .valid_o (dl_valid_s),
    .a_o     (dl_a_s),
    .b_o     (dl_b_s)
  );

  assign load_ready   = load_ready_q;
  assign init         = init_q;
  assign roW          = row_q;
  assign addr_A_read  = a_rd_q;
  assign addr_B_read  = b_rd_q;
  assign addr_A_write = init_q ? dl_a_s : load_addr_q;
  assign addr_B_write = dl_b_s;
  assign tw_addr      = tw_q;
  assign rd_valid     = rd_valid_q;
  assign wr_valid     = dl_valid_s;
  assign stage        = stage_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result_bank  = result_bank_q;

endmodule

// File: doc/fft_addr_ctrl.md
Name: fft_addr_ctrl

Overview:
- Sequencing controller directly upstream of the ping-pong FFT memory. It drives that memory's `init`, `roW` and four address buses, plus the butterfly's twiddle address and valid strobes.
- LOAD phase: N input samples are written in bit-reversed order.
- RUN phase: log2(N) radix-2 DIT stages, with one butterfly read issued per cycle. Write addresses are delayed to match the butterfly pipeline, and banks swap between stages.

Parameters:
- ADDR_WIDTH, 5, log2(N); N = 32 points, ADDR_WIDTH stages.
- BFLY_LATENCY, 3, cycles from read-address issue to butterfly result at memory write port (includes memory read latency); must be >= 1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins LOAD when in IDLE, otherwise ignored.
- load_valid  in  1  input sample present on memory data bus this cycle.
- load_ready  out  1  high in LOAD; sample accepted when load_valid && load_ready.
- init  out  1  0 during LOAD (memory single-write mode), 1 otherwise.
- roW  out  1  bank select for RUN; toggles per stage.
- addr_A_read  out  ADDR_WIDTH  butterfly upper-leg read address.
- addr_B_read  out  ADDR_WIDTH  butterfly lower-leg read address.
- addr_A_write  out  ADDR_WIDTH  write address A (load address during LOAD).
- addr_B_write  out  ADDR_WIDTH  write address B.
- tw_addr  out  ADDR_WIDTH-1  twiddle ROM index for the issued butterfly.
- rd_valid  out  1  read addresses valid this cycle.
- wr_valid  out  1  butterfly result write this cycle (rd_valid delayed BFLY_LATENCY).
- stage  out  ADDR_WIDTH  current stage index, 0..ADDR_WIDTH-1.
- busy  out  1  high in LOAD, RUN or DRAIN.
- done  out  1  one-cycle pulse on completion.
- result_bank  out  1  roW value under which the final result is readable; valid from done onward.

Behaviour:
- Reset values:
  - State IDLE; all counters and the delay line cleared, so wr_valid is 0.
  - All addresses 0; rd_valid, busy, done, load_ready all 0.
  - init=1, roW=0, stage=0, result_bank=0.
- FSM states are IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE -> LOAD on start:
  - init=0, load_ready=1.
  - load_cnt counts accepted samples only; addr_A_write = bitrev(load_cnt).
  - After the accept at load_cnt = N-1: go to RUN, with init=1, roW=0, stage=0, j=0.
  - Gaps in load_valid stall LOAD indefinitely.
- RUN: one butterfly issued per cycle, j = 0..N/2-1, rd_valid=1. With span = 1<<stage:
  - A = ((j >> stage) << (stage+1)) | (j & (span-1)).
  - B = A | span.
  - tw_addr = (j & (span-1)) << (ADDR_WIDTH-1-stage), truncated to ADDR_WIDTH-1 bits.
  - Address and tw_addr outputs are registered and change together with rd_valid.
- RUN -> DRAIN after j = N/2-1.
  - DRAIN lasts exactly BFLY_LATENCY cycles; rd_valid=0 and the read addresses hold their last value.
- Write side:
  - addr_A_write and addr_B_write are the read addresses carried through a BFLY_LATENCY-deep shift register alongside rd_valid.
  - wr_valid is the delayed rd_valid.
  - The delay line is not cleared between stages; it empties naturally during DRAIN.
- End of DRAIN:
  - If stage < ADDR_WIDTH-1: stage+1, roW toggles, j=0, back to RUN in the next cycle.
  - Otherwise: result_bank = roW, then DONE.
- roW never changes while wr_valid=1 or while reads are in flight.
- DONE: done=1 for one cycle, busy=0, then IDLE. Outputs hold; roW holds result_bank.
- start is ignored outside IDLE.
- rst in any state (including mid-LOAD or mid-stage) returns everything to reset values on the next edge. No partial writes are issued after rst.
- Total RUN+DRAIN cycles = ADDR_WIDTH * (N/2 + BFLY_LATENCY); 5 * (16 + 3) = 95 for the defaults.

Decomposition:
- Shared package fft_pkg holds:
  - state enum (IDLE, LOAD, RUN, DRAIN, DONE);
  - a bitrev function parameterised by width;
  - a bfly_addr function (stage, j -> A, B, tw).
- Sub-module fft_delay_line holds the parameterised BFLY_LATENCY-deep shift register of {valid, addrA, addrB}, with synchronous reset. The top level holds the FSM and counters.

Test Plan:
- Reset then start, load_valid held high:
  - load_ready is 1 for exactly 32 cycles.
  - addr_A_write sequence is 0, 16, 8, 24, 4, …, 31.
  - init=0 throughout LOAD, then 1.
- Stage 0 first cycles: (A, B, tw) = (0, 1, 0), (2, 3, 0), … (30, 31, 0).
- Stage 2, j=5: A=9, B=13, tw=4.
- Stage 4, j=15: A=15, B=31, tw=15.
- Write alignment:
  - In every stage, wr_valid pulses 16 cycles, beginning 3 cycles after the first rd_valid.
  - addr_*_write equals addr_*_read from 3 cycles earlier.
  - roW is stable over each stage's full read+write window.
  - roW sequence over stages is 0, 1, 0, 1, 0; done fires 95 cycles after LOAD ends; result_bank=0.
- load_valid toggled 1-0-1-0: LOAD takes 64 cycles and the address order is unchanged.
- Stalls and start handling:
  - A start pulse during RUN has no effect.
  - rst asserted at stage 2, j=7 gives all outputs at reset values on the next cycle, with wr_valid=0.
  - A subsequent start performs a clean full transform.
